mailbox_monitor: RTL and testbench
==================================

MAILBOX_MONITOR -- requirements
Module: mailbox_monitor

Interface
REQ-001 Parameters: BASE_ADDR 32'hD0580000 (channel 0 address); NUM_CH 4 (console channels, power of 2, 1..16); FIFO_DEPTH 16 (power of 2, >=2); TIMEOUT 32'h1800 (cycles to timeout, 0 = disabled).
REQ-002 HCLK  in  1  sole clock, all state on rising edge.
REQ-003 HRESETn  in  1  asynchronous, active-low reset.
REQ-004 HSEL  in  1;  HADDR  in  32;  HTRANS  in  2;  HWRITE  in  1;  HSIZE  in  3;  HREADY  in  1;  HWDATA  in  64: AHB-Lite slave inputs.
REQ-005 HREADYOUT  out  1;  HRESP  out  1;  HRDATA  out  64: AHB-Lite slave outputs.
REQ-006 out_valid  out  1;  out_ready  in  1;  out_char  out  8;  out_ch  out  $clog2(NUM_CH) (min 1): drained console byte stream.
REQ-007 test_done  out  1;  test_pass  out  1;  timeout  out  1;  overflow  out  1: sticky status.
REQ-008 cycle_cnt  out  32: cycles since reset release.

Function
REQ-009 Channel k SHALL occupy the 8-byte word at BASE_ADDR + 8*k, k < NUM_CH; other addresses are unmapped.
REQ-010 Address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; HADDR, HWRITE and hit flag are registered for the data phase.
REQ-011 HREADYOUT SHALL be 1 and HRESP 0 always (zero-wait, OKAY), including for unmapped accesses, which are ignored.
REQ-012 Data-phase write to channel k SHALL capture byte HWDATA[8*a +: 8], a = registered HADDR[2:0], regardless of HSIZE.
REQ-013 Channel 0 byte 8'hFF SHALL set test_done and test_pass; channel 0 byte 8'h01 SHALL set test_done, clear test_pass; neither is pushed to the FIFO.
REQ-014 All other captured bytes SHALL push {k, byte} into a FIFO of FIFO_DEPTH entries in the cycle after the data phase.
REQ-015 Push while full (without a same-cycle pop) SHALL drop the byte and set overflow; FIFO contents unchanged.
REQ-016 out_valid SHALL equal FIFO non-empty; out_char/out_ch show the head entry; pop when out_valid & out_ready.
REQ-017 Simultaneous push and pop when full SHALL succeed (no overflow); when empty, the pushed entry appears next cycle (no bypass).
REQ-018 Read of channel 0 word SHALL return on HRDATA in its data phase: [7:0] count of FIFO entries, [8] test_done, [9] test_pass, [10] timeout, [11] overflow, [63:32] cycle_cnt; other reads return 0.
REQ-019 Write of byte 8'h00 to channel 0 lane 1 (BASE_ADDR+1) SHALL clear overflow only.
REQ-020 cycle_cnt SHALL increment every cycle, saturating at 32'hFFFFFFFF.
REQ-021 If TIMEOUT != 0, timeout SHALL set in the cycle cycle_cnt reaches TIMEOUT while test_done is 0; test_done set in the same cycle wins (timeout stays 0).
REQ-022 Once test_done or timeout is set, further channel-0 pass/fail codes SHALL be ignored; console bytes still accepted.
REQ-023 FIFO pointers SHALL use one extra wrap bit; full = pointers equal except wrap bit; wrap-around at FIFO_DEPTH transparent.

Reset
REQ-024 Assertion of HRESETn low SHALL asynchronously clear FIFO pointers, registered address phase, cycle_cnt, test_done, test_pass, timeout, overflow; out_valid 0, HRDATA 0.
REQ-025 Reset mid-transfer SHALL discard the pending data phase; no push after release.
REQ-026 First count SHALL occur on the first rising HCLK with HRESETn high.

Verification
REQ-027 Write "Hi" as bytes 0x48, 0x69 to BASE_ADDR with out_ready=1 -> out_valid pulses twice, out_char 0x48 then 0x69, out_ch 0.
REQ-028 Write 0x41 to BASE_ADDR+8*2+3 (lane 3) -> single entry out_ch 2, out_char 0x41.
REQ-029 out_ready=0, 17 writes with FIFO_DEPTH 16 -> count reads 16, overflow 1, head still first byte; clear via BASE_ADDR+1 -> overflow 0.
REQ-030 Write 0xFF to BASE_ADDR -> test_done 1, test_pass 1, FIFO count unchanged; later 0x01 -> test_pass stays 1.
REQ-031 TIMEOUT=16, no writes -> timeout 1 at cycle_cnt 16; with 0xFF landing that same cycle -> timeout 0, test_pass 1.
REQ-032 HRESETn low during a write data phase with 3 bytes queued -> out_valid 0 immediately, count 0 after release.

Source files
------------

// File: rtl/mailbox_monitor.sv
// mailbox_monitor: AHB-Lite console mailbox that queues per-channel bytes and tracks test status
module mailbox_monitor #(
    parameter logic [31:0] BASE_ADDR  = 32'hD0580000,
    parameter int          NUM_CH     = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] TIMEOUT    = 32'h1800,
    localparam int         CW         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [63:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [63:0]   HRDATA,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_char,
    output logic [CW-1:0] out_ch,
    output logic          test_done,
    output logic          test_pass,
    output logic          timeout,
    output logic          overflow,
    output logic [31:0]   cycle_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]   off;
    logic          hit;
    logic          dp_valid, dp_write, dp_hit;
    logic [2:0]    dp_lane;
    logic [CW-1:0] dp_ch;
    logic          wr_en, ch0, is_code, is_clr, locked;
    logic          set_pass, set_fail, done_next, push, pop, full, drop, to_hit;
    logic [7:0]    wbyte;
    logic [31:0]   cnt_next;
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic [CW+7:0] mem [FIFO_DEPTH];
    logic [CW+7:0] head;
    logic          unused_ok;

    // HSIZE is irrelevant: every write captures exactly the byte lane named by the address
    assign unused_ok = &{1'b0, HSIZE, HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign off = HADDR - BASE_ADDR;
    assign hit = off < 32'(NUM_CH * 8);

    assign wr_en   = dp_valid & dp_write & dp_hit & HREADY;
    assign wbyte   = HWDATA[8*dp_lane +: 8];
    assign ch0     = dp_ch == '0;
    assign is_code = ch0 & (wbyte == 8'hFF || wbyte == 8'h01);
    assign is_clr  = ch0 & dp_lane == 3'd1 & wbyte == 8'h00;
    assign locked  = test_done | timeout;

    assign set_pass  = wr_en & is_code & ~locked & wbyte == 8'hFF;
    assign set_fail  = wr_en & is_code & ~locked & wbyte == 8'h01;
    assign done_next = test_done | set_pass | set_fail;

    assign cnt_next = &cycle_cnt ? cycle_cnt : cycle_cnt + 32'd1;
    assign to_hit   = TIMEOUT != 32'd0 && cnt_next == TIMEOUT && !done_next;

    assign count     = wr_ptr - rd_ptr;
    assign out_valid = wr_ptr != rd_ptr;
    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign pop       = out_valid & out_ready;
    assign push      = wr_en & ~is_code & ~is_clr;
    assign drop      = push & full & ~pop;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_char = head[7:0];
    assign out_ch   = head[CW+7:8];

    assign HRDATA = (dp_valid & ~dp_write & dp_hit & ch0) ?
                    {cycle_cnt, 20'd0, overflow, timeout, test_pass, test_done, 8'(count)} : 64'd0;

    // Register the accepted address phase for use in the following data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_hit   <= 1'b0;
            dp_lane  <= '0;
            dp_ch    <= '0;
        end else if (HREADY) begin
            dp_valid <= HSEL & HTRANS[1];
            dp_write <= HWRITE;
            dp_hit   <= hit;
            dp_lane  <= off[2:0];
            dp_ch    <= off[3 +: CW];
        end
    end

    // Sticky status flags and the saturating cycle counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cycle_cnt <= '0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cnt_next;
            test_done <= done_next;
            test_pass <= set_pass | (test_pass & ~set_fail);
            timeout   <= timeout | to_hit;
            overflow  <= drop | (overflow & ~(wr_en & is_clr));
        end
    end

    // FIFO pointers with an extra wrap bit; a push into a full FIFO succeeds only alongside a pop
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push & (~full | pop))
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage holds {channel, byte}; contents need no reset
    always_ff @(posedge HCLK) begin
        if (push & (~full | pop))
            mem[wr_ptr[AW-1:0]] <= {dp_ch, wbyte};
    end
endmodule

// File: tb/tb_mailbox_monitor.sv
// tb_mailbox_monitor: directed self-checking bench for mailbox_monitor
module tb_mailbox_monitor;
    localparam logic [31:0] BASE = 32'hD0580000;

    logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA, HRDATA, q;
    logic        out_valid, out_ready, test_done, test_pass, timeout, overflow;
    logic [7:0]  out_char;
    logic [1:0]  out_ch;
    logic [31:0] cycle_cnt;
    int          checks = 0;
    int          failures = 0;

    mailbox_monitor #(.TIMEOUT(32'd16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_ch(out_ch),
        .test_done(test_done), .test_pass(test_pass), .timeout(timeout), .overflow(overflow),
        .cycle_cnt(cycle_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = 3'd0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic wb(input logic [31:0] a, input logic [7:0] b);
        logic [63:0] m;
        m = 64'hFF << (8 * a[2:0]);
        wr(a, (64'hA5A5A5A5A5A5A5A5 & ~m) | (64'(b) << (8 * a[2:0])));
    endtask

    task automatic rd(input logic [31:0] a, output logic [63:0] r);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        r = HRDATA;
    endtask

    task automatic rst();
        @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = '0; HWRITE = 1'b0;
        HSIZE = '0; HREADY = 1'b1; HWDATA = '0; out_ready = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_status", {test_done, test_pass, timeout, overflow}, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        chk("cnt_at_release", cycle_cnt, 0);

        repeat (15) @(negedge HCLK);
        chk("cnt_15", cycle_cnt, 15);
        chk("timeout_15", timeout, 0);
        @(negedge HCLK);
        chk("cnt_16", cycle_cnt, 16);
        chk("timeout_16", timeout, 1);
        rd(BASE, q);
        chk("status_after_timeout", q, {32'd18, 32'h400});
        wb(BASE, 8'hFF);
        @(negedge HCLK);
        chk("pass_ignored_after_timeout", {test_done, test_pass}, 2'b00);
        chk("code_not_pushed", out_valid, 0);

        rst();
        wb(BASE, 8'h01);
        @(negedge HCLK);
        chk("fail_code", {test_done, test_pass}, 2'b10);
        wb(BASE, 8'hFF);
        @(negedge HCLK);
        chk("pass_after_fail_ignored", test_pass, 0);
        repeat (20) @(negedge HCLK);
        chk("no_timeout_when_done", timeout, 0);

        rst();
        repeat (13) @(negedge HCLK);
        wb(BASE, 8'hFF);
        @(negedge HCLK);
        chk("race_cnt", cycle_cnt, 16);
        chk("race_timeout", timeout, 0);
        chk("race_done_pass", {test_done, test_pass}, 2'b11);
        rd(BASE, q);
        chk("pass_count_unchanged", q[11:0], 12'h300);
        wb(BASE, 8'h01);
        @(negedge HCLK);
        chk("pass_sticky", test_pass, 1);

        out_ready = 1'b1;
        wb(BASE, 8'h48);
        @(negedge HCLK);
        chk("hi_h", {out_valid, out_ch, out_char}, {1'b1, 2'd0, 8'h48});
        wb(BASE, 8'h69);
        @(negedge HCLK);
        chk("hi_i", {out_valid, out_ch, out_char}, {1'b1, 2'd0, 8'h69});
        @(negedge HCLK);
        chk("hi_drained", out_valid, 0);

        out_ready = 1'b0;
        wb(BASE + 32'd19, 8'h41);
        @(negedge HCLK);
        chk("lane3_ch2", {out_valid, out_ch, out_char}, {1'b1, 2'd2, 8'h41});
        rd(BASE, q);
        chk("lane3_count", q[11:0], 12'h301);
        out_ready = 1'b1;
        @(negedge HCLK);
        chk("lane3_popped", out_valid, 0);
        out_ready = 1'b0;

        wb(BASE + 32'd32, 8'h55);
        chk("unmapped_hreadyout", {HREADYOUT, HRESP}, 2'b10);
        @(negedge HCLK);
        chk("unmapped_ignored", out_valid, 0);
        rd(BASE + 32'd8, q);
        chk("read_other_ch", q, 0);

        for (int i = 0; i < 17; i++) wb(BASE + 32'd8, 8'(8'h30 + i));
        rd(BASE, q);
        chk("full_status", q[11:0], 12'hB10);
        chk("full_head", {out_ch, out_char}, {2'd1, 8'h30});
        wb(BASE + 32'd1, 8'h00);
        rd(BASE, q);
        chk("ovf_cleared", q[11:0], 12'h310);
        wb(BASE + 32'd8, 8'h40);
        out_ready = 1'b1;
        @(negedge HCLK);
        out_ready = 1'b0;
        rd(BASE, q);
        chk("full_push_pop", q[11:0], 12'h310);
        chk("full_push_pop_head", out_char, 8'h31);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", out_char, (i < 15) ? 8'(8'h31 + i) : 8'h40);
            @(negedge HCLK);
        end
        chk("drain_empty", out_valid, 0);

        out_ready = 1'b0;
        wb(BASE + 32'd8, 8'h61);
        wb(BASE + 32'd8, 8'h62);
        wb(BASE + 32'd8, 8'h63);
        wb(BASE + 32'd8, 8'h64);
        #1 HRESETn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_hrdata", HRDATA, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("midrst_no_push", out_valid, 0);
        chk("midrst_cnt", cycle_cnt, 1);
        rd(BASE, q);
        chk("midrst_status", q, {32'd3, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
